aesl_axis_dst_sink: RTL and testbench

//  Simulation-side AXI-Stream sink: the consuming end of the kernel's dst_buff output stream.

---
 rtl/aesl_axis_dst_sink.sv | 179 +++++++++++++++++
 tb/tb_aesl_axis_dst_sink.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aesl_axis_dst_sink.sv
// ---------------------------------------------------------------------------
// aesl_axis_dst_sink
//
// Simulation-side AXI-Stream sink for the kernel's dst_buff output stream.
// A start pulse arms a run of expected_beats beats. During the run the sink
// accepts beats under one of four back-pressure patterns, keeps a running beat
// count and XOR checksum, and checks TLAST framing. A stall watchdog raises a
// sticky block flag when no beat transfers for STALL_LIMIT cycles in a row.
// This gives cosim a deadlock indication that does not depend on the kernel's
// own monitors. Mode 3 never asserts ready, so it injects a deadlock on purpose.
//
// Ports
//   ap_clk, ap_rst    clock; synchronous active-high reset
//   start             one-cycle pulse: latch expected_beats/bp_mode, arm a run
//   expected_beats    number of beats to accept in the run
//   bp_mode           0 always ready, 1 alternate, 2 LFSR, 3 never ready
//   dst_buff_TDATA    stream data
//   dst_buff_TVALID   stream valid
//   dst_buff_TLAST    stream last
//   dst_buff_TREADY   stream ready (registered)
//   beat_count        beats accepted in this run
//   checksum          XOR of all TDATA accepted in this run
//   done              high (held) once expected_beats have been accepted
//   last_err          sticky: TLAST did not match the final-beat position
//   block             sticky: stall watchdog fired
// ---------------------------------------------------------------------------
module aesl_axis_dst_sink #(
    parameter int          DATA_W      = 32,
    parameter int          STALL_LIMIT = 1024,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              start,
    input  logic [31:0]       expected_beats,
    input  logic [1:0]        bp_mode,
    input  logic [DATA_W-1:0] dst_buff_TDATA,
    input  logic              dst_buff_TVALID,
    input  logic              dst_buff_TLAST,
    output logic              dst_buff_TREADY,
    output logic [31:0]       beat_count,
    output logic [DATA_W-1:0] checksum,
    output logic              done,
    output logic              last_err,
    output logic              block
);

    // stall_cnt only has to hold 0 .. STALL_LIMIT-1.
    localparam int SC_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_DONE    = 2'd2,
        S_BLOCKED = 2'd3
    } state_t;

    state_t          state;
    logic [31:0]     exp_beats;
    logic [1:0]      mode;
    logic [SC_W-1:0] stall_cnt;
    logic [15:0]     lfsr;

    logic            xfer;
    logic            last_beat;
    logic            stall_hit;
    logic [15:0]     lfsr_nxt;
    logic            rdy_entry;
    logic            rdy_stay;

    // A transfer can only happen in RECV. TREADY is already low in every
    // other state, but the state term keeps this explicit.
    assign xfer      = (state == S_RECV) & dst_buff_TVALID & dst_buff_TREADY;
    assign last_beat = (beat_count + 32'd1) == exp_beats;
    assign stall_hit = (stall_cnt == STALL_LAST);

    // 16-bit Fibonacci LFSR with taps 16,14,13,11. It shifts toward the MSB,
    // and the feedback bit enters at bit 0.
    assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Ready for the first RECV cycle. This decodes the bp_mode input directly,
    // because the mode register is loaded on the same edge.
    // In LFSR mode, TREADY always mirrors the current lfsr[0] while in RECV.
    always_comb begin
        rdy_entry = 1'b0;
        unique case (bp_mode)
            2'd0:    rdy_entry = 1'b1;
            2'd1:    rdy_entry = 1'b1;
            2'd2:    rdy_entry = lfsr[0];
            default: rdy_entry = 1'b0;
        endcase
    end

    // Ready for the next cycle while the sink stays in RECV.
    always_comb begin
        rdy_stay = 1'b0;
        unique case (mode)
            2'd0:    rdy_stay = 1'b1;
            2'd1:    rdy_stay = ~dst_buff_TREADY;
            2'd2:    rdy_stay = lfsr_nxt[0];
            default: rdy_stay = 1'b0;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state           <= S_IDLE;
            dst_buff_TREADY <= 1'b0;
            done            <= 1'b0;
            last_err        <= 1'b0;
            block           <= 1'b0;
            beat_count      <= '0;
            checksum        <= '0;
            stall_cnt       <= '0;
            lfsr            <= LFSR_SEED;
            mode            <= 2'd0;
            exp_beats       <= '0;
        end else begin
            unique case (state)
                S_RECV: begin
                    // The LFSR runs every RECV cycle in every mode. It is not
                    // reseeded on start, so each run continues the sequence.
                    lfsr <= lfsr_nxt;
                    if (xfer) begin
                        beat_count <= beat_count + 32'd1;
                        checksum   <= checksum ^ dst_buff_TDATA;
                        stall_cnt  <= '0;
                        if (dst_buff_TLAST != last_beat)
                            last_err <= 1'b1;
                        // The sink leaves RECV on the final beat, so
                        // beat_count never exceeds exp_beats.
                        if (last_beat) begin
                            state           <= S_DONE;
                            done            <= 1'b1;
                            dst_buff_TREADY <= 1'b0;
                        end else begin
                            dst_buff_TREADY <= rdy_stay;
                        end
                    end else if (stall_hit) begin
                        // This is the STALL_LIMIT-th idle cycle in a row.
                        // A transfer on the same cycle takes the branch above,
                        // so a transfer wins over the watchdog.
                        state           <= S_BLOCKED;
                        block           <= 1'b1;
                        dst_buff_TREADY <= 1'b0;
                    end else begin
                        stall_cnt       <= stall_cnt + 1'b1;
                        dst_buff_TREADY <= rdy_stay;
                    end
                end
                default: begin
                    // IDLE, DONE and BLOCKED all re-arm on start. A start in
                    // RECV is ignored.
                    if (start) begin
                        exp_beats  <= expected_beats;
                        mode       <= bp_mode;
                        beat_count <= '0;
                        checksum   <= '0;
                        last_err   <= 1'b0;
                        block      <= 1'b0;
                        stall_cnt  <= '0;
                        if (expected_beats != 32'd0) begin
                            state           <= S_RECV;
                            done            <= 1'b0;
                            dst_buff_TREADY <= rdy_entry;
                        end else begin
                            // Zero-beat run: there is nothing to accept.
                            state           <= S_DONE;
                            done            <= 1'b1;
                            dst_buff_TREADY <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aesl_axis_dst_sink.sv
module tb_aesl_axis_dst_sink;

    localparam int          DW   = 32;
    localparam int          SL   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          start;
    logic [31:0]   expected_beats;
    logic [1:0]    bp_mode;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic [31:0]   beat_count;
    logic [DW-1:0] checksum;
    logic          done;
    logic          last_err;
    logic          block;

    aesl_axis_dst_sink #(.DATA_W(DW), .STALL_LIMIT(SL), .LFSR_SEED(SEED)) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .start           (start),
        .expected_beats  (expected_beats),
        .bp_mode         (bp_mode),
        .dst_buff_TDATA  (tdata),
        .dst_buff_TVALID (tvalid),
        .dst_buff_TLAST  (tlast),
        .dst_buff_TREADY (tready),
        .beat_count      (beat_count),
        .checksum        (checksum),
        .done            (done),
        .last_err        (last_err),
        .block           (block)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_RECV, P_DONE, P_BLK} phase_t;
    phase_t        ph = P_IDLE;
    longint        exp_n = 0;
    int            mmode = 0;
    int            age = 0;       // RECV cycles since the run was armed
    int            idle_run = 0;  // consecutive RECV cycles without a transfer
    logic [15:0]   mlfsr = SEED;
    logic [DW-1:0] acc[$];        // every beat accepted in this run
    bit            lerr = 0;
    bit            blk = 0;
    bit            took = 0;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Length of the zero run in bit 0 that starts after one advance.
    function automatic int zeros_ahead(input logic [15:0] l);
        int n = 0;
        logic [15:0] v = lfsr_adv(l);
        while (!v[0] && n < 20) begin
            n++;
            v = lfsr_adv(v);
        end
        return n;
    endfunction

    function automatic bit exp_ready();
        if (ph != P_RECV) return 1'b0;
        case (mmode)
            0:       return 1'b1;
            1:       return (age % 2) == 0;
            2:       return mlfsr[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_sum();
        logic [DW-1:0] r = '0;
        foreach (acc[i]) r ^= acc[i];
        return r;
    endfunction

    task automatic model_update();
        bit rdy;
        took = 0;
        if (ap_rst) begin
            ph = P_IDLE; acc.delete(); lerr = 0; blk = 0; mlfsr = SEED;
            exp_n = 0; mmode = 0; idle_run = 0; age = 0;
            return;
        end
        if (ph == P_RECV) begin
            rdy = exp_ready();
            if (tvalid && rdy) begin
                took = 1;
                if (tlast != ((longint'(acc.size()) + 1) == exp_n)) lerr = 1;
                acc.push_back(tdata);
                idle_run = 0;
                if (longint'(acc.size()) == exp_n) ph = P_DONE;
            end else begin
                idle_run++;
                if (idle_run == SL) begin
                    blk = 1;
                    ph = P_BLK;
                end
            end
            mlfsr = lfsr_adv(mlfsr);
            age++;
        end else if (start) begin
            acc.delete(); lerr = 0; blk = 0; idle_run = 0; age = 0;
            exp_n = longint'(expected_beats);
            mmode = int'(bp_mode);
            ph = (expected_beats != 0) ? P_RECV : P_DONE;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("tready",   64'(tready),     64'(exp_ready()));
        chk("count",    64'(beat_count), 64'(acc.size()));
        chk("checksum", 64'(checksum),   64'(exp_sum()));
        chk("done",     64'(done),       64'(ph == P_DONE));
        chk("last_err", 64'(last_err),   64'(lerr));
        chk("block",    64'(block),      64'(blk));
    endtask

    task automatic tick();
        @(posedge ap_clk);
        model_update();
        @(negedge ap_clk);
        check_all();
    endtask

    task automatic go(input logic [31:0] n, input logic [1:0] m);
        start = 1; expected_beats = n; bp_mode = m;
        tick();
        start = 0;
    endtask

    // Offers n beats and holds each beat until it is accepted. At most one
    // gap cycle is inserted per beat, and only when the LFSR zero run that
    // follows keeps the stall well under the watchdog limit.
    task automatic stream(input int n, input int last_at, input bit rnd,
                          input int gap_pct, input int budget, output int cyc);
        int sent = 0;
        bit gapped = 0;
        cyc = 0;
        while (sent < n && cyc < budget) begin
            if (!tvalid) begin
                if (!gapped && gap_pct > 0 && $urandom_range(99) < gap_pct
                    && zeros_ahead(mlfsr) < 14) begin
                    gapped = 1;
                end else begin
                    tvalid = 1;
                    tdata  = rnd ? DW'($urandom) : DW'(sent + 1);
                    tlast  = (sent + 1 == last_at);
                    gapped = 0;
                end
            end
            tick();
            cyc++;
            if (took) begin
                sent++;
                tvalid = 0;
                tlast  = 0;
            end
        end
        tvalid = 0;
        tlast  = 0;
        chk("stream_beats", 64'(sent), 64'(n));
    endtask

    initial begin
        int cyc;
        ap_rst = 1; start = 0; expected_beats = 0; bp_mode = 0;
        tdata = '0; tvalid = 0; tlast = 0;
        tick();
        tick();
        chk("rst_tready", 64'(tready), 64'(0));
        chk("rst_count",  64'(beat_count), 64'(0));
        ap_rst = 0;
        tick();

        // T1: always ready, 4 beats on consecutive cycles
        go(4, 0);
        stream(4, 4, 0, 0, 50, cyc);
        chk("t1_cycles", 64'(cyc), 64'(4));
        chk("t1_sum",    64'(checksum), 64'(4));
        chk("t1_done",   64'(done), 64'(1));
        chk("t1_lerr",   64'(last_err), 64'(0));
        tick();

        // T2: alternating ready; the three beats land on every other cycle
        go(3, 1);
        stream(3, 3, 1, 0, 50, cyc);
        chk("t2_cycles", 64'(cyc), 64'(5));
        chk("t2_count",  64'(beat_count), 64'(3));
        chk("t2_done",   64'(done), 64'(1));

        // T3: TLAST on beat 1 of 2
        go(2, 0);
        stream(1, 1, 1, 0, 50, cyc);
        chk("t3_lerr_b1", 64'(last_err), 64'(1));
        stream(1, 0, 1, 0, 50, cyc);
        chk("t3_done", 64'(done), 64'(1));
        chk("t3_lerr", 64'(last_err), 64'(1));

        // Zero-beat run goes straight to done
        go(0, 0);
        chk("zero_done", 64'(done), 64'(1));
        tick();

        // Start while receiving is ignored
        go(3, 0);
        start = 1; expected_beats = 1; bp_mode = 3;
        tick();
        start = 0;
        stream(3, 3, 1, 0, 50, cyc);
        chk("ign_count", 64'(beat_count), 64'(3));

        // T4: never ready, watchdog fires on the 16th idle cycle
        go(5, 3);
        tvalid = 1; tdata = DW'(32'h55); tlast = 0;
        for (int i = 0; i < SL - 1; i++) tick();
        chk("t4_pre_block", 64'(block), 64'(0));
        tick();
        chk("t4_block", 64'(block), 64'(1));
        chk("t4_count", 64'(beat_count), 64'(0));
        tvalid = 0;
        tick();

        // T5: LFSR back-pressure, random data and gaps, restarted from BLOCKED
        go(100, 2);
        chk("t5_block_clr", 64'(block), 64'(0));
        stream(100, 100, 1, 25, 3000, cyc);
        chk("t5_done",  64'(done), 64'(1));
        chk("t5_block", 64'(block), 64'(0));
        chk("t5_count", 64'(beat_count), 64'(100));

        // T6: reset partway through a run, then a full run
        go(4, 0);
        stream(2, 0, 1, 0, 50, cyc);
        ap_rst = 1;
        tick();
        chk("t6_cnt_rst", 64'(beat_count), 64'(0));
        chk("t6_sum_rst", 64'(checksum), 64'(0));
        ap_rst = 0;
        tick();
        go(4, 0);
        stream(4, 4, 1, 0, 50, cyc);
        chk("t6_count", 64'(beat_count), 64'(4));
        chk("t6_done",  64'(done), 64'(1));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
